// File: rtl/moldudp64_hdr_seq.sv
// MoldUDP64 header parser: captures the 20-byte header from a beat stream, marks the
// payload bytes that follow, and tracks the expected sequence number per session.
module moldudp64_hdr_seq #(
  parameter int DATA_W    = 64,
  parameter bit SEQ_CHECK = 1'b1
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        valid_i,
  input  logic                        start_i,
  input  logic                        last_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        sess_clr_i,
  output logic                        hdr_v_o,
  output logic [79:0]                 sid_o,
  output logic [63:0]                 seq_num_o,
  output logic [15:0]                 msg_cnt_o,
  output logic                        heartbeat_o,
  output logic                        eos_o,
  output logic                        sync_o,
  output logic                        gap_o,
  output logic [63:0]                 gap_len_o,
  output logic                        dup_o,
  output logic                        pl_v_o,
  output logic [$clog2(DATA_W/8):0]   pl_off_o,
  output logic                        runt_o,
  output logic                        busy_o
);

  localparam int BYTES     = DATA_W / 8;
  localparam int HDR_BEATS = (20 + BYTES - 1) / BYTES;
  localparam int REM       = 20 % BYTES;
  localparam int CNT_W     = $clog2(HDR_BEATS + 1);
  localparam int OFF_W     = $clog2(BYTES) + 1;
  localparam int BUF_W     = (HDR_BEATS - 1) * DATA_W;
  localparam int HDR_W     = HDR_BEATS * DATA_W;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   beat_cnt_reg, beat_idx;
  logic [BUF_W-1:0]   hdr_buf_reg;
  logic [159:0]       hdr_bytes;
  logic               hdr_beat, hdr_done, runt_det;

  logic [79:0]        sid_cap;
  logic [63:0]        seq_cap, cnt_ext, eff_cnt, end_seq, raw_end, exp_seq_next;
  logic [15:0]        cnt_cap;
  logic               is_hb, is_eos, resync, gap_det, dup_det;

  logic [63:0]        exp_seq_reg;
  logic [79:0]        exp_sid_reg;
  logic               in_sync_reg, clr_pend_reg;
  logic               sync_reg, gap_reg, dup_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // A start beat always restarts capture, whatever state the FSM is in.
  always_comb begin
    state_next = state_reg;
    if (hdr_beat) begin
      if (last_i)        state_next = IDLE;
      else if (hdr_done) state_next = PAYLOAD;
      else               state_next = HDR;
    end else if (valid_i && last_i && state_reg == PAYLOAD) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    hdr_beat = valid_i & (start_i | (state_reg == HDR));
    beat_idx = start_i ? '0 : beat_cnt_reg;
    hdr_done = hdr_beat & (beat_idx == CNT_W'(HDR_BEATS - 1));
    runt_det = hdr_beat & last_i & ~hdr_done;
    pl_v_o   = 1'b0;
    pl_off_o = '0;
    if (hdr_done && REM != 0) begin
      pl_v_o   = 1'b1;
      pl_off_o = OFF_W'(REM);
    end else if (valid_i && !start_i && state_reg == PAYLOAD) begin
      pl_v_o   = 1'b1;
    end
    busy_o = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      beat_cnt_reg <= '0;
      hdr_buf_reg  <= '0;
    end else if (hdr_beat) begin
      beat_cnt_reg <= beat_idx + CNT_W'(1);
      hdr_buf_reg  <= {hdr_buf_reg[BUF_W-DATA_W-1:0], data_i};
    end
  end

  // Earlier beats sit in the buffer; the final beat is taken straight from the input.
  assign hdr_bytes = 160'({hdr_buf_reg, data_i} >> (HDR_W - 160));
  assign sid_cap   = hdr_bytes[159:80];
  assign seq_cap   = hdr_bytes[79:16];
  assign cnt_cap   = hdr_bytes[15:0];

  always_comb begin
    is_hb   = (cnt_cap == 16'h0000);
    is_eos  = (cnt_cap == 16'hFFFF);
    cnt_ext = {48'd0, cnt_cap};
    eff_cnt = is_eos ? 64'd0 : cnt_ext;
    end_seq = seq_cap + eff_cnt;
    raw_end = seq_cap + cnt_ext;
    resync  = ~in_sync_reg | (sid_cap != exp_sid_reg) | clr_pend_reg | sess_clr_i;
    gap_det = ~resync & (seq_cap > exp_seq_reg);
    dup_det = ~resync & ~gap_det & (raw_end <= exp_seq_reg) & ~is_hb & ~is_eos;
    if (resync || gap_det)          exp_seq_next = end_seq;
    else if (end_seq > exp_seq_reg) exp_seq_next = end_seq;
    else                            exp_seq_next = exp_seq_reg;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hdr_v_o      <= 1'b0;
      runt_o       <= 1'b0;
      heartbeat_o  <= 1'b0;
      eos_o        <= 1'b0;
      sync_reg     <= 1'b0;
      gap_reg      <= 1'b0;
      dup_reg      <= 1'b0;
      sid_o        <= '0;
      seq_num_o    <= '0;
      msg_cnt_o    <= '0;
      gap_len_o    <= '0;
      exp_seq_reg  <= '0;
      exp_sid_reg  <= '0;
      in_sync_reg  <= 1'b0;
      clr_pend_reg <= 1'b0;
    end else begin
      hdr_v_o     <= hdr_done;
      runt_o      <= runt_det;
      heartbeat_o <= hdr_done & is_hb;
      eos_o       <= hdr_done & is_eos;
      sync_reg    <= hdr_done & resync;
      gap_reg     <= hdr_done & gap_det;
      dup_reg     <= hdr_done & dup_det;
      if (hdr_done) begin
        sid_o        <= sid_cap;
        seq_num_o    <= seq_cap;
        msg_cnt_o    <= cnt_cap;
        gap_len_o    <= seq_cap - exp_seq_reg;
        exp_seq_reg  <= exp_seq_next;
        exp_sid_reg  <= sid_cap;
        in_sync_reg  <= 1'b1;
        clr_pend_reg <= 1'b0;
      end else if (sess_clr_i) begin
        clr_pend_reg <= 1'b1;
      end
    end
  end

  assign sync_o = SEQ_CHECK ? sync_reg : 1'b0;
  assign gap_o  = SEQ_CHECK ? gap_reg  : 1'b0;
  assign dup_o  = SEQ_CHECK ? dup_reg  : 1'b0;

endmodule

// File: tb/tb_moldudp64_hdr_seq.sv
// Bench for moldudp64_hdr_seq: directed and randomized packets on a 64-bit instance
// checked against a packet-level model, plus first-scenario runs at 8/16/32 bits.
module tb_moldudp64_hdr_seq;

  localparam logic [79:0] SID_A = 80'h0102030405060708090A;
  localparam logic [79:0] SID_B = 80'hA1A2A3A4A5A6A7A8A9AA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset = 1'b0, sub_nreset = 1'b0;
  logic valid_i = 1'b0, start_i = 1'b0, last_i = 1'b0, sess_clr_i = 1'b0;
  logic [63:0] data_i = '0;

  logic        hdr_v_o, heartbeat_o, eos_o, sync_o, gap_o, dup_o, pl_v_o, runt_o, busy_o;
  logic [79:0] sid_o;
  logic [63:0] seq_num_o, gap_len_o;
  logic [15:0] msg_cnt_o;
  logic [3:0]  pl_off_o;

  int checks = 0, failures = 0;
  logic [2:0] sub_done = '0;

  moldudp64_hdr_seq #(.DATA_W(64), .SEQ_CHECK(1'b1)) dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .start_i(start_i), .last_i(last_i),
    .data_i(data_i), .sess_clr_i(sess_clr_i), .hdr_v_o(hdr_v_o), .sid_o(sid_o),
    .seq_num_o(seq_num_o), .msg_cnt_o(msg_cnt_o), .heartbeat_o(heartbeat_o), .eos_o(eos_o),
    .sync_o(sync_o), .gap_o(gap_o), .gap_len_o(gap_len_o), .dup_o(dup_o), .pl_v_o(pl_v_o),
    .pl_off_o(pl_off_o), .runt_o(runt_o), .busy_o(busy_o)
  );

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endfunction

  function automatic void chkw(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Session model state and the expected registered outputs for the next cycle.
  logic        m_in_sync = 1'b0, m_clr = 1'b0;
  logic [79:0] m_sid = '0;
  logic [63:0] m_seq = '0;
  logic        nxt_v = 0, nxt_runt = 0, nxt_hb = 0, nxt_eos = 0, nxt_sync = 0, nxt_gap = 0, nxt_dup = 0;
  logic [79:0] nxt_sid = '0;
  logic [63:0] nxt_seq = '0, nxt_glen = '0;
  logic [15:0] nxt_cnt = '0;
  logic        cur_v, cur_runt, cur_hb, cur_eos, cur_sync, cur_gap, cur_dup;
  logic [79:0] held_sid;
  logic [63:0] held_seq, cur_glen;
  logic [15:0] held_cnt;
  logic        exp_pl_v = 1'b0;
  logic [3:0]  exp_pl_off = '0;
  logic        fin_v;
  logic [3:0]  fin_off;

  function automatic void clear_nxt();
    nxt_v = 0; nxt_runt = 0; nxt_hb = 0; nxt_eos = 0; nxt_sync = 0; nxt_gap = 0; nxt_dup = 0;
  endfunction

  function automatic void model_hdr(input logic [79:0] sid, input logic [63:0] seq,
                                    input logic [15:0] cnt, input logic clr);
    logic [63:0] end_seq;
    end_seq = seq + ((cnt == 16'hFFFF) ? 64'd0 : {48'd0, cnt});
    nxt_v = 1; nxt_sid = sid; nxt_seq = seq; nxt_cnt = cnt;
    nxt_hb = (cnt == 16'h0000); nxt_eos = (cnt == 16'hFFFF);
    if (!m_in_sync || sid != m_sid || m_clr || clr) begin
      nxt_sync = 1; m_seq = end_seq; m_sid = sid; m_in_sync = 1;
    end else if (seq > m_seq) begin
      nxt_gap = 1; nxt_glen = seq - m_seq; m_seq = end_seq;
    end else begin
      nxt_dup = (seq + {48'd0, cnt} <= m_seq) && !nxt_hb && !nxt_eos;
      if (end_seq > m_seq) m_seq = end_seq;
    end
    m_clr = 0;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cur_v <= 0; cur_runt <= 0; cur_hb <= 0; cur_eos <= 0; cur_sync <= 0; cur_gap <= 0;
      cur_dup <= 0; cur_glen <= '0; held_sid <= '0; held_seq <= '0; held_cnt <= '0;
    end else begin
      cur_v <= nxt_v; cur_runt <= nxt_runt; cur_hb <= nxt_hb; cur_eos <= nxt_eos;
      cur_sync <= nxt_sync; cur_gap <= nxt_gap; cur_dup <= nxt_dup; cur_glen <= nxt_glen;
      if (nxt_v) begin
        held_sid <= nxt_sid; held_seq <= nxt_seq; held_cnt <= nxt_cnt;
      end
    end
  end

  always @(negedge clk) begin
    chk1("hdr_v", hdr_v_o, cur_v);
    chk1("runt", runt_o, cur_runt);
    chk1("heartbeat", heartbeat_o, cur_hb);
    chk1("eos", eos_o, cur_eos);
    chk1("sync", sync_o, cur_sync);
    chk1("gap", gap_o, cur_gap);
    chk1("dup", dup_o, cur_dup);
    if (cur_gap) chkw("gap_len", 80'(gap_len_o), 80'(cur_glen));
    chkw("sid", sid_o, held_sid);
    chkw("seq_num", 80'(seq_num_o), 80'(held_seq));
    chkw("msg_cnt", 80'(msg_cnt_o), 80'(held_cnt));
    chk1("pl_v", pl_v_o, exp_pl_v);
    if (exp_pl_v) chkw("pl_off", 80'(pl_off_o), 80'(exp_pl_off));
  end

  task automatic idle(input int n, input bit garbage, input bit clr);
    repeat (n) begin
      @(posedge clk); #1;
      valid_i = garbage & 1'($urandom);
      start_i = 0; last_i = 1'($urandom); data_i = {$urandom, $urandom};
      sess_clr_i = clr; exp_pl_v = 0; clear_nxt();
      if (clr) m_clr = 1;
    end
  endtask

  // Header is 3 beats at 64 bits; byte 20 starts at lane 4 of beat 2.
  task automatic send_pkt(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt,
                          input int nb, input bit with_last, input int bub_pct, input bit clr_final);
    logic [7:0] bytes [48];
    for (int k = 0; k < 48; k++) bytes[k] = 8'($urandom);
    for (int k = 0; k < 10; k++) bytes[k] = sid[79-8*k -: 8];
    for (int k = 0; k < 8; k++) bytes[10+k] = seq[63-8*k -: 8];
    bytes[18] = cnt[15:8];
    bytes[19] = cnt[7:0];
    for (int i = 0; i < nb; i++) begin
      while ($urandom_range(0, 99) < bub_pct) idle(1, 0, 0);
      @(posedge clk); #1;
      valid_i = 1; start_i = (i == 0); last_i = with_last && (i == nb - 1);
      sess_clr_i = clr_final && (i == 2);
      for (int l = 0; l < 8; l++) data_i[63-8*l -: 8] = bytes[8*i+l];
      exp_pl_v = (i >= 2); exp_pl_off = (i == 2) ? 4'd4 : 4'd0;
      clear_nxt();
      nxt_runt = last_i && (i < 2);
      if (i == 2) begin
        model_hdr(sid, seq, cnt, sess_clr_i);
        #1; fin_v = pl_v_o; fin_off = pl_off_o;
      end
    end
  endtask

  initial begin
    logic [79:0] sid;
    logic [63:0] seq;
    logic [15:0] cnt;
    int kind, nb;
    bit wl;
    repeat (3) @(posedge clk);
    #1; nreset = 1; sub_nreset = 1;
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_hdr_v", hdr_v_o, 1'b0);
    chkw("rst_sid", sid_o, 80'd0);

    send_pkt(SID_A, 64'd100, 16'd3, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t1_hdr_v", hdr_v_o, 1'b1);
    chkw("t1_sid", sid_o, SID_A);
    chkw("t1_seq", 80'(seq_num_o), 80'd100);
    chkw("t1_cnt", 80'(msg_cnt_o), 80'd3);
    chk1("t1_sync", sync_o, 1'b1);
    chk1("t1_pl_v", fin_v, 1'b1);
    chkw("t1_pl_off", 80'(fin_off), 80'd4);

    send_pkt(SID_A, 64'd103, 16'd2, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t2_sync", sync_o, 1'b0); chk1("t2_gap", gap_o, 1'b0); chk1("t2_dup", dup_o, 1'b0);

    send_pkt(SID_A, 64'd110, 16'd1, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t3_gap", gap_o, 1'b1); chkw("t3_gap_len", 80'(gap_len_o), 80'd5);

    send_pkt(SID_A, 64'd104, 16'd2, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t4_dup", dup_o, 1'b1); chk1("t4_gap", gap_o, 1'b0);

    send_pkt(SID_A, 64'd111, 16'd0, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t5_hb", heartbeat_o, 1'b1); chk1("t5_gap", gap_o, 1'b0);

    send_pkt(SID_A, 64'd111, 16'hFFFF, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t6_eos", eos_o, 1'b1); chk1("t6_gap", gap_o, 1'b0);

    send_pkt(SID_A, 64'd111, 16'd1, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t7_gap", gap_o, 1'b0); chk1("t7_dup", dup_o, 1'b0);

    send_pkt(SID_A, 64'd0, 16'd0, 2, 1, 0, 0); idle(1, 0, 0);
    chk1("t8_runt", runt_o, 1'b1); chk1("t8_hdr_v", hdr_v_o, 1'b0);

    send_pkt(SID_A, 64'd112, 16'd1, 5, 0, 0, 0);
    send_pkt(SID_A, 64'd113, 16'd2, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t9_hdr_v", hdr_v_o, 1'b1); chkw("t9_seq", 80'(seq_num_o), 80'd113);
    chkw("t9_cnt", 80'(msg_cnt_o), 80'd2); chk1("t9_gap", gap_o, 1'b0);

    send_pkt(SID_A, 64'd115, 16'd1, 3, 1, 50, 0); idle(1, 0, 0);
    chkw("t10_seq", 80'(seq_num_o), 80'd115); chk1("t10_sync", sync_o, 1'b0);
    chk1("t10_gap", gap_o, 1'b0);

    send_pkt(SID_B, 64'd500, 16'd4, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t11_sync", sync_o, 1'b1); chk1("t11_gap", gap_o, 1'b0);

    send_pkt(SID_B, 64'd504, 16'd1, 2, 0, 0, 0); idle(1, 0, 0);
    chk1("t12_busy", busy_o, 1'b1);
    nreset = 0; m_in_sync = 0; m_clr = 0;
    #1;
    chk1("t12_busy0", busy_o, 1'b0); chk1("t12_hdr_v0", hdr_v_o, 1'b0);
    chkw("t12_sid0", sid_o, 80'd0); chkw("t12_seq0", 80'(seq_num_o), 80'd0);
    chk1("t12_sync0", sync_o, 1'b0);
    @(posedge clk); #1; nreset = 1;
    send_pkt(SID_B, 64'd505, 16'd1, 3, 1, 0, 0); idle(1, 0, 0);
    chk1("t12_sync", sync_o, 1'b1);

    for (int k = 0; k < 250; k++) begin
      sid = ($urandom % 2 != 0) ? SID_A : SID_B;
      if (m_in_sync && m_sid == sid && $urandom % 20 != 0)
        seq = m_seq + 64'($urandom_range(0, 12)) - 64'd6;
      else
        seq = {$urandom, $urandom};
      case ($urandom % 10)
        0:       cnt = 16'h0000;
        1:       cnt = 16'hFFFF;
        default: cnt = 16'($urandom_range(1, 8));
      endcase
      kind = $urandom % 10;
      if (kind == 0)      begin nb = $urandom_range(1, 2); wl = 1; end
      else if (kind == 1) begin nb = $urandom_range(1, 5); wl = 0; end
      else                begin nb = $urandom_range(3, 6); wl = 1; end
      send_pkt(sid, seq, cnt, nb, wl, ($urandom % 4 == 0) ? 30 : 0, ($urandom % 15 == 0));
      idle($urandom_range(0, 2), wl, ($urandom % 20 == 0));
    end
    idle(5, 0, 0);
    chk1("sub_done", &sub_done, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Narrower instances run the first scenario once: seq=100, cnt=3, 4 payload bytes.
  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W   = 8 << gi;
    localparam int B   = W / 8;
    localparam int NB  = 24 / B;
    localparam int FIN = (20 + B - 1) / B - 1;
    logic v = 0, s = 0, l = 0;
    logic [W-1:0] d = '0;
    logic w_hdr_v, w_hb, w_eos, w_sync, w_gap, w_dup, w_pl_v, w_runt, w_busy;
    logic [79:0] w_sid;
    logic [63:0] w_seq, w_glen;
    logic [15:0] w_cnt;
    logic [$clog2(B):0] w_off;

    moldudp64_hdr_seq #(.DATA_W(W), .SEQ_CHECK(1'b1)) dut_w (
      .clk(clk), .nreset(sub_nreset), .valid_i(v), .start_i(s), .last_i(l), .data_i(d),
      .sess_clr_i(1'b0), .hdr_v_o(w_hdr_v), .sid_o(w_sid), .seq_num_o(w_seq),
      .msg_cnt_o(w_cnt), .heartbeat_o(w_hb), .eos_o(w_eos), .sync_o(w_sync), .gap_o(w_gap),
      .gap_len_o(w_glen), .dup_o(w_dup), .pl_v_o(w_pl_v), .pl_off_o(w_off),
      .runt_o(w_runt), .busy_o(w_busy)
    );

    initial begin
      logic [7:0] bytes [24];
      logic [79:0] sid_lit;
      logic [63:0] seq_lit;
      sid_lit = SID_A;
      seq_lit = 64'd100;
      for (int k = 0; k < 10; k++) bytes[k] = sid_lit[79-8*k -: 8];
      for (int k = 0; k < 8; k++) bytes[10+k] = seq_lit[63-8*k -: 8];
      bytes[18] = 8'h00; bytes[19] = 8'h03;
      for (int k = 20; k < 24; k++) bytes[k] = 8'hE0 + 8'(k);
      wait (sub_nreset == 1'b1);
      for (int i = 0; i < NB; i++) begin
        @(posedge clk); #1;
        v = 1; s = (i == 0); l = (i == NB - 1);
        for (int j = 0; j < B; j++) d[W-1-8*j -: 8] = bytes[i*B+j];
        #1;
        if (i == FIN) begin
          chk1($sformatf("w%0d_pl_v", W), w_pl_v, (20 % B) != 0);
          chkw($sformatf("w%0d_pl_off", W), 80'(w_off), 80'(20 % B));
          chk1($sformatf("w%0d_hdr_v_early", W), w_hdr_v, 1'b0);
        end
        if (i == FIN + 1) begin
          chk1($sformatf("w%0d_hdr_v", W), w_hdr_v, 1'b1);
          chkw($sformatf("w%0d_sid", W), w_sid, SID_A);
          chkw($sformatf("w%0d_seq", W), 80'(w_seq), 80'd100);
          chkw($sformatf("w%0d_cnt", W), 80'(w_cnt), 80'd3);
          chk1($sformatf("w%0d_sync", W), w_sync, 1'b1);
        end
      end
      @(posedge clk); #1;
      v = 0; s = 0; l = 0;
      sub_done[gi] = 1'b1;
    end
  end

endmodule
